// File: rtl/tow_scoreboard_if.sv
// Bundle between the push-ball game block (master) and the scoreboard (slave):
// ball position in, round-clear / LEDs / score digits / match flag out.
interface tow_scoreboard_if;
    logic [9:0] ball_pos;
    logic       round_clear;
    logic [9:0] LEDG;
    logic [6:0] HEX0_D;
    logic [6:0] HEX3_D;
    logic       match_over;

    modport master (
        output ball_pos,
        input  round_clear, LEDG, HEX0_D, HEX3_D, match_over
    );
    modport slave (
        input  ball_pos,
        output round_clear, LEDG, HEX0_D, HEX3_D, match_over
    );
endinterface

// File: rtl/tow_scoreboard.sv
// Push-ball scoreboard: wall detection, round celebration, score digits, match latch.
// Define TOW_WIN_BY_TWO_EN to require a two-point lead (or a score of 9) to end the match.
module tow_scoreboard #(
    parameter int unsigned WIN_SCORE    = 5,
    parameter int unsigned HOLD_CYCLES  = 50_000_000,
    parameter int unsigned BLINK_CYCLES = 12_500_000
) (
    input logic             CLOCK_50,
    input logic             RESET,
    tow_scoreboard_if.slave sb_io
);
    localparam int unsigned HoldW  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int unsigned BlinkW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [HoldW-1:0]  HoldLast  = HoldW'(HOLD_CYCLES - 1);
    localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINK_CYCLES - 1);
    localparam logic [3:0] WinScore = 4'(WIN_SCORE);

    // Ball on the left wall means the right player took the round, and vice versa.
    localparam logic [9:0] RightWinsPos = 10'b1000000000;
    localparam logic [9:0] LeftWinsPos  = 10'b0000000001;
    localparam logic [9:0] HalfLeft     = 10'b0000011111;
    localparam logic [9:0] HalfRight    = 10'b1111100000;
    localparam logic [6:0] SegZero      = 7'b1000000;

    typedef enum logic [2:0] {StPlay, StHold, StClear, StArm, StOver} state_e;

    state_e            state_q, state_d;
    logic [3:0]        score_l_q, score_l_d, score_r_q, score_r_d;
    logic [HoldW-1:0]  hold_cnt_q, hold_cnt_d;
    logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
    logic              blink_q, blink_d;
    logic              winner_left_q, winner_left_d;
    logic [6:0]        hex0_q, hex0_d, hex3_q, hex3_d;

    logic       hit_left, hit_right, hit_wall, hold_done, match_won;
    logic [3:0] win_score, lose_score;
    logic [9:0] win_half;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v >= 4'd9) ? 4'd9 : v + 4'd1;
    endfunction

    assign hit_left   = (sb_io.ball_pos == LeftWinsPos);
    assign hit_right  = (sb_io.ball_pos == RightWinsPos);
    assign hit_wall   = hit_left | hit_right;
    assign hold_done  = (hold_cnt_q == HoldLast);
    assign win_score  = winner_left_q ? score_l_q : score_r_q;
    assign lose_score = winner_left_q ? score_r_q : score_l_q;
    assign win_half   = winner_left_q ? HalfLeft : HalfRight;

`ifdef TOW_WIN_BY_TWO_EN
    assign match_won = (win_score == 4'd9) ||
                       ((win_score >= WinScore) &&
                        ({1'b0, win_score} >= ({1'b0, lose_score} + 5'd2)));
`else
    assign match_won = (win_score == WinScore);
`endif

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state_q <= StPlay;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StPlay:  if (hit_wall) state_d = StHold;
            StHold:  if (hold_done) state_d = match_won ? StOver : StClear;
            StClear: state_d = StArm;
            StArm:   if (!hit_wall) state_d = StPlay;
            StOver:  state_d = StOver;
            default: state_d = StPlay;
        endcase
    end

    always_comb begin
        score_l_d     = score_l_q;
        score_r_d     = score_r_q;
        hold_cnt_d    = hold_cnt_q;
        blink_cnt_d   = blink_cnt_q;
        blink_d       = blink_q;
        winner_left_d = winner_left_q;
        // Digits trail the score by one clock.
        hex0_d        = seg7(score_r_q);
        hex3_d        = seg7(score_l_q);
        if (state_q == StPlay && hit_wall) begin
            winner_left_d = hit_left;
            if (hit_left) begin
                score_l_d = sat_inc(score_l_q);
            end else begin
                score_r_d = sat_inc(score_r_q);
            end
            hold_cnt_d  = '0;
            blink_cnt_d = '0;
            blink_d     = 1'b1;
        end else if (state_q == StHold) begin
            hold_cnt_d = hold_done ? '0 : hold_cnt_q + HoldW'(1);
            if (blink_cnt_q == BlinkLast) begin
                blink_cnt_d = '0;
                blink_d     = ~blink_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BlinkW'(1);
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            score_l_q     <= '0;
            score_r_q     <= '0;
            hold_cnt_q    <= '0;
            blink_cnt_q   <= '0;
            blink_q       <= 1'b0;
            winner_left_q <= 1'b0;
            hex0_q        <= SegZero;
            hex3_q        <= SegZero;
        end else begin
            score_l_q     <= score_l_d;
            score_r_q     <= score_r_d;
            hold_cnt_q    <= hold_cnt_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_q       <= blink_d;
            winner_left_q <= winner_left_d;
            hex0_q        <= hex0_d;
            hex3_q        <= hex3_d;
        end
    end

    always_comb begin
        sb_io.LEDG        = sb_io.ball_pos;
        sb_io.round_clear = 1'b0;
        sb_io.match_over  = 1'b0;
        unique case (state_q)
            StPlay, StArm: sb_io.LEDG = sb_io.ball_pos;
            StHold:        sb_io.LEDG = blink_q ? win_half : '0;
            StClear: begin
                sb_io.LEDG        = '0;
                sb_io.round_clear = 1'b1;
            end
            StOver: begin
                sb_io.LEDG       = win_half;
                sb_io.match_over = 1'b1;
            end
            default: sb_io.LEDG = sb_io.ball_pos;
        endcase
    end

    assign sb_io.HEX0_D = hex0_q;
    assign sb_io.HEX3_D = hex3_q;
endmodule

// File: doc/tow_scoreboard.md
Name: tow_scoreboard

Overview:
- Downstream stage of the push-ball game; consumes the 10-bit one-hot ball position and owns the board LEDs and score displays.
- Detects a ball reaching either wall and awards the round.
- Holds a blink celebration, issues a one-cycle round-clear to the game block, and keeps match score on two 7-segment digits until the match is won.

Parameters:
- WIN_SCORE, 5, rounds needed to win the match (1..9).
- HOLD_CYCLES, 50_000_000, celebration length in clocks (1 s at 50 MHz).
- BLINK_CYCLES, 12_500_000, LED blink half-period in clocks.

Ports:
- CLOCK_50  in  1  system clock.
- RESET  in  1  synchronous, active-high reset.
- ball_pos  in  10  one-hot ball position from the game block; bit9 = left wall, bit0 = right wall.
- round_clear  out  1  one-cycle pulse; game block recentres the ball on it.
- LEDG  out  10  green LEDs.
- HEX0_D  out  7  right-player score, active-low segments gfedcba.
- HEX3_D  out  7  left-player score, active-low segments gfedcba.
- match_over  out  1  high while a match winner is latched.

Behaviour:
- Reset values, on the first clock edge with RESET=1:
  - state=PLAY; both scores 0; blink/hold counters 0.
  - round_clear=0, match_over=0, LEDG=ball_pos (pass-through).
  - HEX0_D=HEX3_D=7'b1000000 (digit 0).
- Wall mapping:
  - ball_pos==10'b1000000000 → right player wins the round.
  - ball_pos==10'b0000000001 → left player wins the round.
  - Any other value, including zero or multi-hot, is a non-win; it never scores.
- States:
  - PLAY:
    - LEDG=ball_pos.
    - On a wall value, the winner's score increments in that same edge and the block goes to HOLD.
    - winner_is_left is latched.
  - HOLD:
    - The hold counter counts 0..HOLD_CYCLES-1.
    - The blink bit toggles each BLINK_CYCLES clocks, starting at 1.
    - LEDG = blink ? winner half : 0, where the winner half is 10'b0000011111 for left and 10'b1111100000 for right.
    - At terminal count: if the winner's score == WIN_SCORE, go to OVER; else go to CLEAR.
  - CLEAR:
    - round_clear=1 for exactly one cycle; LEDG=0.
    - Next state is ARM.
  - ARM:
    - LEDG=ball_pos.
    - Waits until ball_pos is not a wall value, then goes to PLAY.
    - Prevents double-scoring while the game block applies the clear.
  - OVER:
    - match_over=1; LEDG=winner half, steady.
    - The block stays in OVER until RESET; ball_pos is ignored.
- Exactly one score increments per round, regardless of how long ball_pos sits at a wall.
- Scores are 4-bit and saturate at 9.
- HEX decode, active low:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- HEX outputs are registered and update one cycle after the score changes.
- RESET mid-HOLD or mid-OVER aborts immediately to the reset values. No round_clear is emitted; the game block is reset by its own button.
- round_clear never asserts in PLAY, ARM or OVER.

Optional Feature:
- Macro: TOW_WIN_BY_TWO_EN.
- Defined: at HOLD terminal count, the match ends only when the winner's score ≥ WIN_SCORE and the winner leads by ≥ 2, or the winner's score has reached 9. Otherwise the block goes to CLEAR.
- Undefined: the match ends when the winner's score == WIN_SCORE, with no lead requirement.

Test Plan (HOLD_CYCLES=8, BLINK_CYCLES=2, WIN_SCORE=3):
- Reset → LEDG follows ball_pos=10'b0000010000; HEX0_D=HEX3_D=7'b1000000; round_clear=0; match_over=0.
- ball_pos=10'b0000000001 held 20 cycles:
  - Left score goes to 1 once; HEX3_D=7'b1111001 one cycle later.
  - LEDG alternates 10'b0000011111 / 0 every 2 cycles for 8 cycles.
  - round_clear pulses exactly one cycle.
  - No further score while the wall value persists.
- After the clear, ball_pos returns to centre → state returns to PLAY; LEDG follows ball_pos again.
- Three right-wall rounds (ball_pos=10'b1000000000):
  - HEX0_D steps 1, 2, 3.
  - After the third HOLD: match_over=1, LEDG=10'b1111100000 steady, no round_clear.
  - ball_pos changes are ignored.
- RESET asserted during HOLD → next edge: scores 0, LEDG=ball_pos, no round_clear pulse.
- With TOW_WIN_BY_TWO_EN defined, left 3 vs right 2 → no match_over (CLEAR instead). Left 4 vs right 2 → match_over=1.
